// File: rtl/reg_file_16x16_pkg.sv
// rtl/reg_file_16x16_pkg.sv - shared widths, sizes and register-ID type for the register file
package reg_file_16x16_pkg;
    localparam int DATA_W_DEFAULT = 16;
    localparam int REG_ID_W       = 4;
    localparam int NREG           = 16;

    typedef logic [REG_ID_W-1:0] reg_id_t;
endpackage

// File: rtl/reg_file_16x16_if.sv
// rtl/reg_file_16x16_if.sv - read/write/reserve port bundle of the register file
interface reg_file_16x16_if
    import reg_file_16x16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic              rd_en;
    reg_id_t           src_a;
    reg_id_t           src_b;
    logic              wr_en;
    reg_id_t           dst;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    reg_id_t           rsv_id;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              rvalid;
    logic              hazard_a;
    logic              hazard_b;
    logic [NREG-1:0]   pending;

    modport master (
        output rd_en, src_a, src_b, wr_en, dst, wr_data, rsv_en, rsv_id,
        input  rdata_a, rdata_b, rvalid, hazard_a, hazard_b, pending
    );

    modport slave (
        input  rd_en, src_a, src_b, wr_en, dst, wr_data, rsv_en, rsv_id,
        output rdata_a, rdata_b, rvalid, hazard_a, hazard_b, pending
    );
endinterface

// File: rtl/reg_file_16x16_wordline_dec_4_16.sv
// rtl/reg_file_16x16_wordline_dec_4_16.sv - 4-bit register ID to one-hot 16-bit wordline
module wordline_dec_4_16
    import reg_file_16x16_pkg::*;
(
    input  reg_id_t         id,
    output logic [NREG-1:0] wl
);
    always_comb begin
        wl     = '0;
        wl[id] = 1'b1;
    end
endmodule

// File: rtl/reg_file_16x16.sv
// rtl/reg_file_16x16.sv - 16-entry register file with pending scoreboard; REG_FILE_BYPASS_EN adds write-to-read forwarding
module reg_file_16x16
    import reg_file_16x16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
)(
    input logic              clk,
    input logic              rst_n,
    reg_file_16x16_if.slave  bus
);
    localparam logic [NREG-1:0] REG0_MASK = {{(NREG-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   wr_wl;
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_next;
    logic [NREG-1:0]   rsv_mask;
    logic [NREG-1:0]   clr_mask;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rd_val_a, rd_val_b;
    logic              byp_a, byp_b;

    wordline_dec_4_16 u_wr_dec (
        .id (bus.dst),
        .wl (wr_wl)
    );

`ifdef REG_FILE_BYPASS_EN
    assign byp_a = bus.wr_en && (bus.dst == bus.src_a) && (bus.src_a != '0);
    assign byp_b = bus.wr_en && (bus.dst == bus.src_b) && (bus.src_b != '0);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign rd_val_a = byp_a ? bus.wr_data : regs[bus.src_a];
    assign rd_val_b = byp_b ? bus.wr_data : regs[bus.src_b];

    // Set after clear so a same-register reserve and write leaves the bit set.
    assign rsv_mask  = bus.rsv_en ? (REG0_MASK << bus.rsv_id) : '0;
    assign clr_mask  = bus.wr_en ? wr_wl : '0;
    assign pend_next = ((pend_q & ~clr_mask) | rsv_mask) & ~REG0_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            pend_q    <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            regs[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (bus.wr_en && wr_wl[i]) regs[i] <= bus.wr_data;
            end
            pend_q   <= pend_next;
            rvalid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rdata_a_q <= rd_val_a;
                rdata_b_q <= rd_val_b;
            end
        end
    end

    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.pending  = pend_q;
    assign bus.hazard_a = pend_q[bus.src_a] & ~byp_a;
    assign bus.hazard_b = pend_q[bus.src_b] & ~byp_b;
endmodule

// File: doc/reg_file_16x16.md
REG_FILE_16X16 -- requirements
Module: reg_file_16x16

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, register width; NREG, fixed 16, register count (4-bit IDs).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rd_en  input  1  capture a read of src_a/src_b this cycle.
REQ-005 src_a, src_b  input  4 each  source register IDs.
REQ-006 wr_en  input  1  commit wr_data to dst this cycle.
REQ-007 dst  input  4  write register ID.
REQ-008 wr_data  input  DATA_W  write data.
REQ-009 rsv_en  input  1  mark rsv_id pending (instruction issued, result outstanding).
REQ-010 rsv_id  input  4  register to reserve.
REQ-011 rdata_a, rdata_b  output  DATA_W each  registered read data.
REQ-012 rvalid  output  1  rdata_a/rdata_b valid; asserted the cycle after rd_en.
REQ-013 hazard_a, hazard_b  output  1 each  combinational: source register pending.
REQ-014 pending  output  16  scoreboard bit vector, bit i = register i pending.

Function
REQ-015 Storage: 16 x DATA_W flops; write on rising clk when wr_en=1 to the register selected by a one-hot 16-bit write wordline decoded from dst.
REQ-016 Register 0 SHALL read as 0; writes to 0 and reservations of 0 SHALL be ignored; pending[0] always 0.
REQ-017 Read latency: 1 cycle; at edge with rd_en=1, rdata_a <= value of src_a, rdata_b <= value of src_b; rvalid <= 1.
REQ-018 At edge with rd_en=0, rdata_a/rdata_b SHALL hold; rvalid <= 0.
REQ-019 Without bypass, a read and write of the same register in one cycle returns the old value.
REQ-020 Scoreboard: rsv_en sets pending[rsv_id]; wr_en clears pending[dst]; each at the next edge.
REQ-021 Same register reserved and written in one cycle: pending SHALL end set (reserve wins, newer producer).
REQ-022 Different registers reserved and written in one cycle: both updates apply.
REQ-023 Reserving an already-pending register: stays set, no error; writing a non-pending register: write occurs, bit stays clear.
REQ-024 hazard_a = pending[src_a]; hazard_b = pending[src_b]; not dependent on rd_en; subject to REQ-029.
REQ-025 rd_en while hazard asserted SHALL still capture (stale) data; stalling is the issuer's responsibility.

Reset
REQ-026 On rst_n=0, immediately: all registers 0, pending 0, rdata_a 0, rdata_b 0, rvalid 0.
REQ-027 Reset mid-operation aborts any in-flight read; first edge after release with no inputs asserted leaves all outputs 0.

Configuration
REQ-028 Macro REG_FILE_BYPASS_EN SHALL enable write-to-read forwarding.
REQ-029 Defined: when wr_en=1 and dst=src (nonzero) in the rd_en cycle, captured rdata = wr_data, and hazard for that source is forced 0 that cycle. Undefined: REQ-019 holds, hazard unmodified.

Structure
REQ-030 Shared package SHALL hold DATA_W default, REG_ID_W=4, NREG=16 and the register-ID type.
REQ-031 One sub-module, wordline_dec_4_16: 4-bit ID in, one-hot 16-bit wordline out, used for the write port.

Verification
REQ-032 Reset then rd_en src_a=3,src_b=0 -> next cycle rdata_a=0, rdata_b=0, rvalid=1.
REQ-033 wr_en dst=5 data=16'hBEEF; next cycle rd_en src_a=5 -> rdata_a=16'hBEEF one cycle later; write dst=0 16'h1234 then read 0 -> 0.
REQ-034 rsv_en id=7 -> pending=16'h0080, hazard_a=1 for src_a=7; wr_en dst=7 -> pending=0, hazard_a=0.
REQ-035 Same cycle rsv_en id=9 and wr_en dst=9 -> pending[9]=1 after edge; rsv id=2 with wr dst=4 (4 pending) -> pending=16'h0004.
REQ-036 Same cycle wr_en dst=6 data=16'h00AA, rd_en src_b=6 (old 16'h0011) -> rdata_b=16'h00AA with REG_FILE_BYPASS_EN, 16'h0011 without.
REQ-037 rst_n pulsed low asynchronously mid-cycle after writes/reservations -> all outputs 0 immediately, registers read 0 after release.
